// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial multi-digit BCD adder.
//
// One BCD digit is added per clock, least significant digit first, through a
// single decimal-correct digit slice. The inter-digit carry lives in a flop.
// Result digits shift into sum from the MSB end, so after DIGITS shifts
// digit 0 sits in sum[3:0].
//
// Handshake: start is accepted in IDLE or DONE. busy is high while digits are
// processed (DIGITS cycles). done is a one-cycle pulse once sum, cout and
// invalid are final. sum and cout hold until the next accepted start.
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    request a new operation (ignored while busy)
//   a, b     packed BCD operands, digit 0 in bits [3:0]
//   cin      decimal carry-in to digit 0
//   sub      (only with BCD_SERIAL_ADDER_SUB_EN) 1 = compute a - b
//   busy     digits being processed
//   done     one-cycle result-valid pulse
//   sum      packed BCD result
//   cout     decimal carry-out (with sub: 1 = no borrow)
//   invalid  some A or B digit was greater than 9 in the last operation
//
// Optional feature macro: BCD_SERIAL_ADDER_SUB_EN adds the sub port. When sub
// is 1 the B digits are nines'-complemented and the carry is seeded with 1,
// giving a ten's-complement subtraction; cin is then ignored.
module bcd_serial_adder #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
`ifdef BCD_SERIAL_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Decimal digit slice: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                               input logic [3:0] y,
                                               input logic       c);
    logic [4:0] raw;
    logic [4:0] adj;
    raw = {1'b0, x} + {1'b0, y} + {4'b0, c};
    adj = raw + 5'd6;
    if (raw > 5'd9)
      bcd_digit_add = {1'b1, adj[3:0]};
    else
      bcd_digit_add = {1'b0, raw[3:0]};
  endfunction

  logic [1:0]          state;
  logic [CNT_W-1:0]    cnt;
  logic [4*DIGITS-1:0] a_sr;
  logic [4*DIGITS-1:0] b_sr;
  logic                carry;
  logic [4*DIGITS-1:0] sum_q;
  logic                cout_q;
  logic                invalid_q;
  logic                carry_seed;

  logic [3:0]          b_eff;
  logic [4:0]          slice;
  logic [4*DIGITS+3:0] sum_ext;
  logic                dig_bad;

`ifdef BCD_SERIAL_ADDER_SUB_EN
  logic sub_q;
  // Nines' complement of B; wraps mod 16 for non-BCD digits.
  assign b_eff      = sub_q ? 4'(4'd9 - b_sr[3:0]) : b_sr[3:0];
  assign carry_seed = sub ? 1'b1 : cin;
`else
  assign b_eff      = b_sr[3:0];
  assign carry_seed = cin;
`endif

  assign slice   = bcd_digit_add(a_sr[3:0], b_eff, carry);
  // Invalid check looks at the original B digit, not the complemented one.
  assign dig_bad = (a_sr[3:0] > 4'd9) || (b_sr[3:0] > 4'd9);
  assign sum_ext = {slice[3:0], sum_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
`ifdef BCD_SERIAL_ADDER_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else begin
      case (state)
        RUN: begin
          // One digit per edge; operands shift right, result enters at MSB.
          a_sr  <= a_sr >> 4;
          b_sr  <= b_sr >> 4;
          carry <= slice[4];
          sum_q <= sum_ext[4*DIGITS+3:4];
          if (dig_bad)
            invalid_q <= 1'b1;
          if (cnt == LAST) begin
            cnt    <= '0;
            cout_q <= slice[4];
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new operation.
          if (start) begin
            a_sr      <= a;
            b_sr      <= b;
            carry     <= carry_seed;
            invalid_q <= 1'b0;
            cnt       <= '0;
            state     <= RUN;
`ifdef BCD_SERIAL_ADDER_SUB_EN
            sub_q     <= sub;
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed testbench for bcd_serial_adder (DIGITS=4). Build with
// +define+BCD_SERIAL_ADDER_SUB_EN to include the subtraction vectors.
module tb_bcd_serial_adder;

  localparam int DIGITS = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
`ifdef BCD_SERIAL_ADDER_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        invalid;

  int nvec;
  int nerr;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
`ifdef BCD_SERIAL_ADDER_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .invalid (invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done, counting edges; returns the edge count (capped at 20).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Launch one operation, wait for done, check latency and results.
  task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tci, input logic [15:0] esum, input logic ecout,
                       input logic einv);
    int lat;
    a = ta; b = tb_v; cin = tci; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(DIGITS));
    chk({tag, "_sum"}, 32'(sum), 32'(esum));
    chk({tag, "_cout"}, 32'(cout), 32'(ecout));
    chk({tag, "_inv"}, 32'(invalid), 32'(einv));
  endtask

  initial begin
    int lat;
    logic seen_done;
    nvec = 0; nerr = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef BCD_SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_inv", 32'(invalid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain add, then done drops and sum holds.
    do_op("add", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
    tick();
    chk("add_done_pulse", 32'(done), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);
    chk("add_hold", 32'(sum), 32'h6912);

    // Full carry ripple and carry-in.
    do_op("ripple", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    do_op("cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    tick();

    // Invalid digit: A digit 0 = 0xA -> 0 with carry into digit 1.
    do_op("inv", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
    tick();
    // Invalid digit in a higher position: 0xA in digit 1 carries into digit 2.
    do_op("inv_hi", 16'h00A0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1);
    tick();
    do_op("inv_clr", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    tick();

    // start held high through RUN; operands change after E0.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h9999; b = 16'h9999; cin = 1'b1;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    start = 1'b0;
    chk("hold_lat", 32'(lat), 32'(DIGITS));
    chk("hold_sum", 32'(sum), 32'h3333);
    chk("hold_cout", 32'(cout), 32'd0);
    tick();
    chk("hold_idle", 32'(busy), 32'd0);
    tick();

    // Back-to-back: start in the done cycle.
    do_op("b2b1", 16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0);
    a = 16'h0005; b = 16'h0005; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'(DIGITS));
    chk("b2b_sum", 32'(sum), 32'h0010);
    chk("b2b_cout", 32'(cout), 32'd0);
    tick();

    // Reset mid-run after E2.
    a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
    tick();                      // E0
    start = 1'b0;
    tick();                      // E1
    tick();                      // E2
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_cout", 32'(cout), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    chk("mrst_no_done", 32'(seen_done), 32'd0);
    do_op("post_rst", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
    tick();

`ifdef BCD_SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op("sub1", 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b1, 1'b0);
    tick();
    do_op("sub2", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0);
    tick();
    sub = 1'b0;
    do_op("sub_off", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
